// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a req/ack data-memory handshake, a timeout and the MEM/WB register.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  WB_MEM,
  input  logic [2:0]  MEM_MEM,
  input  logic [4:0]  WN_MEM,
  input  logic [31:0] RD2_WD_MEM,
  input  logic [31:0] ALUOut_MEM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [1:0]  WB_WB,
  output logic [4:0]  WN_WB,
  output logic [31:0] RD_WB,
  output logic [31:0] ALUOut_WB,
  output logic [1:0]  err_WB
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic mem_read, mem_write, access, misalign, go, timeout_now, rd_cap, unused_memtoreg;
  assign mem_read = MEM_MEM[2];
  assign mem_write = MEM_MEM[1];
  assign unused_memtoreg = MEM_MEM[0];
  assign access = mem_read | mem_write;
  assign misalign = access & (ALUOut_MEM[1:0] != 2'b00);
  assign go = access & ~misalign;
  assign timeout_now = go & ~dmem_ack & (cnt == LAST);
  assign stall = go & ~dmem_ack & ~timeout_now;
  assign rd_cap = go & dmem_ack & mem_read & ~mem_write;
  assign dmem_req = go;
  assign dmem_we = mem_write;
  assign dmem_addr = ALUOut_MEM;
  assign dmem_wdata = RD2_WD_MEM;
  // A timeout in the first request cycle (TIMEOUT = 1) must not enter WAIT.
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == IDLE) begin
      state_nx = stall ? WAIT : IDLE;
      cnt_nx = stall ? CW'(1) : '0;
    end else begin
      state_nx = stall ? WAIT : IDLE;
      cnt_nx = stall ? cnt + 1'b1 : '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      WB_WB <= '0;
      WN_WB <= '0;
      RD_WB <= '0;
      ALUOut_WB <= '0;
      err_WB <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      WB_WB <= (stall | misalign | timeout_now) ? 2'b00 : WB_MEM;
      err_WB <= {timeout_now, misalign};
      if (!stall && !timeout_now) begin
        WN_WB <= WN_MEM;
        ALUOut_WB <= ALUOut_MEM;
      end
      if (rd_cap) RD_WB <= dmem_rdata;
    end
  end
endmodule
